// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the core (port C) and the loader/DMA (port D).
// Optional build macro MEM_ARB_STARVE_GUARD_EN bounds how long C may hold the bus while D waits.
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int DMA_BURST_MAX = 8,
    parameter int STARVE_LIMIT  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int NP  = 2;
    localparam int PC  = 0;
    localparam int PD  = 1;
    localparam int BCW = $clog2(DMA_BURST_MAX) + 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(DMA_BURST_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } owner_t;

    owner_t         owner_q, owner_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [NP-1:0]  rd_pend_q, rd_pend_d;

    logic [NP-1:0]  port_req;
    logic [NP-1:0]  port_we;
    logic [NP-1:0]  port_own;
    logic [NP-1:0]  port_gnt;
    logic [AW-1:0]  port_addr  [NP];
    logic [DW-1:0]  port_wdata [NP];

    assign port_req        = {d_req, c_req};
    assign port_we         = {d_we, c_we};
    assign port_own        = {owner_q == OWN_D, owner_q == OWN_C};
    assign port_addr[PC]   = c_addr;
    assign port_addr[PD]   = d_addr;
    assign port_wdata[PC]  = c_wdata;
    assign port_wdata[PD]  = d_wdata;

    // A grant is the owner's live request; reset suppresses any access in flight.
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_port
            assign port_gnt[gi]  = ~reset & port_req[gi] & port_own[gi];
            assign rd_pend_d[gi] = port_gnt[gi] & ~port_we[gi];
        end
    endgenerate

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NP; i++) begin
            if (port_gnt[i]) begin
                mem_we    = port_we[i];
                mem_addr  = port_addr[i];
                mem_wdata = port_wdata[i];
            end
        end
    end

    assign c_gnt    = port_gnt[PC];
    assign d_gnt    = port_gnt[PD];
    assign c_stall  = c_req & ~c_gnt;
    assign c_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    // Read data lands one cycle after the grant; steer only the strobe to that port.
    assign c_rvalid = rd_pend_q[PC] & ~reset;
    assign d_rvalid = rd_pend_q[PD] & ~reset;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SCW-1:0] STARVE_LAST = SCW'(STARVE_LIMIT - 1);

    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Guard compiled out: the limit only describes the disabled option.
    if (STARVE_LIMIT < 0) begin : g_starve_limit_unused
    end
`endif

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
`ifdef MEM_ARB_STARVE_GUARD_EN
        starve_cnt_d = starve_cnt_q;
`endif
        case (owner_q)
            IDLE: begin
                if (c_req) begin
                    owner_d = OWN_C;
                end else if (d_req) begin
                    owner_d = OWN_D;
                end
            end
            OWN_C: begin
                if (!c_req) begin
                    owner_d = d_req ? OWN_D : IDLE;
                end
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (!c_req) begin
                    starve_cnt_d = '0;
                end else if (d_req) begin
                    // Last C grant the waiting loader has to tolerate: hand over next cycle.
                    if (starve_cnt_q >= STARVE_LAST) begin
                        owner_d      = OWN_D;
                        starve_cnt_d = '0;
                    end else begin
                        starve_cnt_d = starve_cnt_q + SCW'(1);
                    end
                end
`endif
            end
            OWN_D: begin
                // The grant at BURST_LAST is the final one; IDLE then gives C a slot.
                if (!d_req || burst_cnt_q >= BURST_LAST) begin
                    owner_d     = IDLE;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + BCW'(1);
                end
            end
            default: begin
                owner_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= IDLE;
            burst_cnt_q <= '0;
            rd_pend_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    a_gnt_exclusive: assert property (@(posedge clk) disable iff (reset) !(c_gnt && d_gnt));
    a_we_needs_gnt:  assert property (@(posedge clk) disable iff (reset) mem_we |-> (c_gnt || d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BURST  = 8;
    localparam int STARVE = 16;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0, d_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, mem_we;
    logic [DW-1:0] c_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem    [0:63];
    logic [DW-1:0] shadow [0:63];

    mem_port_arbiter #(.AW(AW), .DW(DW), .DMA_BURST_MAX(BURST), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(int i);
        return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Behavioural single-port memory with one-cycle synchronous read.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEAD_BEEF;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got gnt/rv/we=%b expected 00000", i, {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we});
            end
            checks++;
            if (mem_addr !== '0 || mem_wdata !== '0) begin
                errors++;
                $display("FAIL reset_mem_bus cyc%0d: got addr=%h wdata=%h expected 0", i, mem_addr, mem_wdata);
            end
            next_cycle();
        end
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({c_gnt, d_gnt, c_stall} !== 3'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got gnt/stall=%b expected 000", {c_gnt, d_gnt, c_stall});
        end
        next_cycle();
        $display("test_reset done");
    endtask

    task automatic test_core_read();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (c_stall !== 1'b1 || c_gnt !== 1'b0) begin
            errors++;
            $display("FAIL core_read_arb_cycle: got stall=%b gnt=%b expected stall=1 gnt=0", c_stall, c_gnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1 || c_stall !== 1'b0) begin
            errors++;
            $display("FAIL core_read_gnt: got gnt=%b stall=%b expected gnt=1 stall=0", c_gnt, c_stall);
        end
        checks++;
        if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL core_read_bus: got addr=%h we=%b expected addr=40 we=0", mem_addr, mem_we);
        end
        next_cycle();
        c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_rvalid: got c_rv=%b d_rv=%b expected 1 0", c_rvalid, d_rvalid);
        end
        checks++;
        if (c_rdata !== init_word(16)) begin
            errors++;
            $display("FAIL core_read_data: got %h expected %h", c_rdata, init_word(16));
        end
        next_cycle();
        $display("test_core_read done");
    endtask

    task automatic test_priority();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        @(negedge clk);
        checks++;
        if ({c_gnt, d_gnt, c_stall} !== 3'b001) begin
            errors++;
            $display("FAIL prio_arb_cycle: got c_gnt,d_gnt,stall=%b expected 001", {c_gnt, d_gnt, c_stall});
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({c_gnt, d_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL prio_c_first cyc%0d: got c_gnt,d_gnt=%b expected 10", i, {c_gnt, d_gnt});
            end
            next_cycle();
        end
        c_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({c_gnt, d_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL prio_release_cycle: got c_gnt,d_gnt=%b expected 00", {c_gnt, d_gnt});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || mem_addr !== 32'h20) begin
            errors++;
            $display("FAIL prio_d_after_c: got d_gnt=%b addr=%h expected 1 20", d_gnt, mem_addr);
        end
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || d_rdata !== init_word(8)) begin
            errors++;
            $display("FAIL prio_d_read: got d_rv=%b c_rv=%b data=%h expected 1 0 %h", d_rvalid, c_rvalid, d_rdata, init_word(8));
        end
        next_cycle();
        $display("test_priority done");
    endtask

    task automatic test_dma_burst();
        int  gnt_cnt;
        logic exp;
        gnt_cnt = 0;
        do_reset();
        d_req = 1'b1; d_we = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d_addr  = 32'($urandom_range(0, 63)) << 2;
            d_wdata = $urandom;
            exp = ((i % (BURST + 1)) != 0);
            @(negedge clk);
            checks++;
            if (d_gnt !== exp || mem_we !== exp) begin
                errors++;
                $display("FAIL dma_burst_gnt cyc%0d: got d_gnt=%b we=%b expected %b", i, d_gnt, mem_we, exp);
            end
            if (exp) begin
                checks++;
                if (mem_addr !== d_addr || mem_wdata !== d_wdata) begin
                    errors++;
                    $display("FAIL dma_burst_bus cyc%0d: got %h/%h expected %h/%h", i, mem_addr, mem_wdata, d_addr, d_wdata);
                end
            end
            if (d_gnt === 1'b1) gnt_cnt++;
            next_cycle();
        end
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt_cnt != 17 || d_gnt !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dma_burst_total: got %0d grants (d_gnt=%b rv=%b) expected 17 (0 0)", gnt_cnt, d_gnt, d_rvalid);
        end
        next_cycle();
        $display("test_dma_burst done: %0d grants", gnt_cnt);
    endtask

    task automatic test_owner_switch();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88;
        next_cycle();
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1) begin
            errors++;
            $display("FAIL switch_c_gnt: got %b expected 1", c_gnt);
        end
        next_cycle();
        c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0 || c_rdata !== init_word(17)) begin
            errors++;
            $display("FAIL switch_c_return: got c_rv=%b d_rv=%b data=%h expected 1 0 %h", c_rvalid, d_rvalid, c_rdata, init_word(17));
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || c_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL switch_d_gnt: got d_gnt=%b c_rv=%b expected 1 0", d_gnt, c_rvalid);
        end
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || d_rdata !== init_word(34)) begin
            errors++;
            $display("FAIL switch_d_return: got d_rv=%b c_rv=%b data=%h expected 1 0 %h", d_rvalid, c_rvalid, d_rdata, init_word(34));
        end
        next_cycle();
        $display("test_owner_switch done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0C;
        next_cycle();
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_gnt: got %b expected 1", c_gnt);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b0 || c_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drop: got rv=%b gnt=%b expected 0 0", c_rvalid, c_gnt);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b0 || c_rvalid !== 1'b0 || c_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_idle: got gnt=%b rv=%b stall=%b expected 0 0 1", c_gnt, c_rvalid, c_stall);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_regrant: got %b expected 1", c_gnt);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        $display("test_reset_mid done");
    endtask

    task automatic test_starve();
        int c_cnt;
        int d_cnt;
        int first_d;
        c_cnt = 0; d_cnt = 0; first_d = -1;
        do_reset();
        c_req = 1'b1; c_we = 1'b1;
        d_req = 1'b1; d_we = 1'b1;
        for (int i = 0; i < 40; i++) begin
            c_addr = 32'($urandom_range(0, 63)) << 2; c_wdata = $urandom;
            d_addr = 32'($urandom_range(0, 63)) << 2; d_wdata = $urandom;
            @(negedge clk);
            checks++;
            if (c_gnt === 1'b1 && d_gnt === 1'b1) begin
                errors++;
                $display("FAIL starve_exclusive cyc%0d: got both grants expected at most one", i);
            end
            if (d_gnt === 1'b1) begin
                d_cnt++;
                if (first_d < 0) first_d = i;
            end
            if (c_gnt === 1'b1 && first_d < 0) c_cnt++;
            next_cycle();
        end
        checks++;
        if (GUARD) begin
            if (c_cnt != STARVE || first_d != STARVE + 1) begin
                errors++;
                $display("FAIL starve_guard: got %0d c_gnt then d_gnt at cyc %0d expected %0d then %0d", c_cnt, first_d, STARVE, STARVE + 1);
            end
        end else begin
            if (d_cnt != 0 || c_cnt != 39) begin
                errors++;
                $display("FAIL starve_noguard: got d_gnt=%0d c_gnt=%0d expected 0 39", d_cnt, c_cnt);
            end
        end
        idle_inputs();
        next_cycle();
        next_cycle();
        $display("test_starve done: c=%0d d=%0d first_d=%0d", c_cnt, d_cnt, first_d);
    endtask

    // Reference model: who holds the bus, grants taken by D this tenure, C grants while D waited.
    task automatic test_random();
        int            who;
        int            d_taken;
        int            c_waited;
        bit            pend_c, pend_d;
        logic [DW-1:0] pend_data;
        logic          e_cg, e_dg, e_we, e_crv, e_drv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        who = 0; d_taken = 0; c_waited = 0; pend_c = 0; pend_d = 0; pend_data = '0;
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            reset   = (n == 0) || ($urandom_range(0, 99) < 2);
            c_req   = c_req ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
            d_req   = d_req ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            c_we    = $urandom_range(0, 1) == 1;
            d_we    = $urandom_range(0, 1) == 1;
            c_addr  = 32'($urandom_range(0, 63)) << 2;
            d_addr  = 32'($urandom_range(0, 63)) << 2;
            c_wdata = $urandom;
            d_wdata = $urandom;

            e_cg    = !reset && c_req && who == 1;
            e_dg    = !reset && d_req && who == 2;
            e_we    = e_cg ? c_we    : (e_dg ? d_we    : 1'b0);
            e_addr  = e_cg ? c_addr  : (e_dg ? d_addr  : '0);
            e_wdata = e_cg ? c_wdata : (e_dg ? d_wdata : '0);
            e_crv   = !reset && pend_c;
            e_drv   = !reset && pend_d;

            @(negedge clk);
            checks++;
            if (c_gnt !== e_cg || d_gnt !== e_dg) begin
                errors++;
                $display("FAIL rand_gnt n=%0d: got c=%b d=%b expected c=%b d=%b", n, c_gnt, d_gnt, e_cg, e_dg);
            end
            checks++;
            if (!reset && c_stall !== (c_req && !e_cg)) begin
                errors++;
                $display("FAIL rand_stall n=%0d: got %b expected %b", n, c_stall, c_req && !e_cg);
            end
            checks++;
            if (mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                errors++;
                $display("FAIL rand_bus n=%0d: got we=%b %h/%h expected we=%b %h/%h", n, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
            end
            checks++;
            if (c_rvalid !== e_crv || d_rvalid !== e_drv) begin
                errors++;
                $display("FAIL rand_rvalid n=%0d: got c=%b d=%b expected c=%b d=%b", n, c_rvalid, d_rvalid, e_crv, e_drv);
            end
            if (e_crv || e_drv) begin
                checks++;
                if ((e_crv ? c_rdata : d_rdata) !== pend_data) begin
                    errors++;
                    $display("FAIL rand_rdata n=%0d: got %h expected %h", n, e_crv ? c_rdata : d_rdata, pend_data);
                end
            end

            @(posedge clk);
            if (reset) begin
                who = 0; d_taken = 0; c_waited = 0; pend_c = 0; pend_d = 0;
                for (int k = 0; k < 64; k++) shadow[k] = init_word(k);
            end else begin
                pend_c = e_cg && !c_we;
                pend_d = e_dg && !d_we;
                if (pend_c || pend_d) pend_data = shadow[e_addr[7:2]];
                if (e_we) shadow[e_addr[7:2]] = e_wdata;
                case (who)
                    0: who = c_req ? 1 : (d_req ? 2 : 0);
                    1: begin
                        if (!c_req) begin
                            who = d_req ? 2 : 0;
                            c_waited = 0;
                        end else if (GUARD && d_req) begin
                            c_waited++;
                            if (c_waited == STARVE) begin
                                who = 2;
                                c_waited = 0;
                            end
                        end
                    end
                    default: begin
                        if (!d_req) begin
                            who = 0;
                            d_taken = 0;
                        end else begin
                            d_taken++;
                            if (d_taken == BURST) begin
                                who = 0;
                                d_taken = 0;
                            end
                        end
                    end
                endcase
            end
            #1;
        end
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_priority();
        test_dma_burst();
        test_owner_switch();
        test_reset_mid();
        test_starve();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
